// File: rtl/div_job_sequencer.sv
// Operand sequencer for the 8-bit by 7-bit restoring divider: queues host requests, launches
// them one at a time, and returns tagged results with divide-by-zero and timeout handling.
module div_job_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [6:0]              req_divisor,
    input  logic [7:0]              req_dividend,
    input  logic [TAG_W-1:0]        req_tag,
    output logic [6:0]              div_divisor,
    output logic [7:0]              div_dividend,
    output logic                    div_start,
    input  logic                    div_valid,
    input  logic [7:0]              div_quotient,
    input  logic [6:0]              div_remainder,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [7:0]              rsp_quotient,
    output logic [6:0]              rsp_remainder,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [1:0]              rsp_err,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ErrOk      = 2'b00;
    localparam logic [1:0] ErrDivZero = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    state_e             state;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [TW-1:0]      timer;
    logic               prev_valid;
    logic [TAG_W-1:0]   cur_tag;

    logic [6:0]         fifo_divisor  [DEPTH];
    logic [7:0]         fifo_dividend [DEPTH];
    logic [TAG_W-1:0]   fifo_tag      [DEPTH];

    logic               push;
    logic               pop;
    logic               done;
    logic [6:0]         head_divisor;
    logic [7:0]         head_dividend;
    logic [TAG_W-1:0]   head_tag;

    // Ready and pop both look only at registered count, so a freshly pushed entry waits a cycle.
    assign req_ready     = count < CW'(DEPTH);
    assign push          = req_valid && req_ready;
    assign pop           = (state == StIdle) && (count != '0);
    assign done          = div_valid && !prev_valid;
    assign busy          = (state != StIdle) || (count != '0);
    assign head_divisor  = fifo_divisor[rd_ptr];
    assign head_dividend = fifo_dividend[rd_ptr];
    assign head_tag      = fifo_tag[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_divisor[wr_ptr]  <= req_divisor;
            fifo_dividend[wr_ptr] <= req_dividend;
            fifo_tag[wr_ptr]      <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            timer         <= '0;
            prev_valid    <= 1'b0;
            cur_tag       <= '0;
            div_divisor   <= '0;
            div_dividend  <= '0;
            div_start     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_tag       <= '0;
            rsp_err       <= ErrOk;
        end else begin
            prev_valid <= div_valid;
            div_start  <= 1'b0;

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            unique case (state)
                StIdle: begin
                    if (pop) begin
                        div_divisor  <= head_divisor;
                        div_dividend <= head_dividend;
                        cur_tag      <= head_tag;
                        if (head_divisor == 7'd0) begin
                            rsp_valid     <= 1'b1;
                            rsp_quotient  <= 8'hFF;
                            rsp_remainder <= head_dividend[6:0];
                            rsp_tag       <= head_tag;
                            rsp_err       <= ErrDivZero;
                            state         <= StResp;
                        end else begin
                            // Registered pulse: high for exactly the LAUNCH cycle.
                            div_start <= 1'b1;
                            state     <= StLaunch;
                        end
                    end
                end
                StLaunch: begin
                    timer <= '0;
                    state <= StWait;
                end
                StWait: begin
                    if (done) begin
                        rsp_valid     <= 1'b1;
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_tag       <= cur_tag;
                        rsp_err       <= ErrOk;
                        state         <= StResp;
                    end else if (timer == TW'(TIMEOUT)) begin
                        rsp_valid     <= 1'b1;
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_tag       <= cur_tag;
                        rsp_err       <= ErrTimeout;
                        state         <= StResp;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_job_sequencer.sv
// Scoreboard bench for div_job_sequencer with a behavioural divider model.
module tb_div_job_sequencer;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_divisor;
    logic [7:0] req_dividend;
    logic [1:0] req_tag;
    logic [6:0] div_divisor;
    logic [7:0] div_dividend;
    logic       div_start;
    logic       div_valid;
    logic [7:0] div_quotient;
    logic [6:0] div_remainder;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_quotient;
    logic [6:0] rsp_remainder;
    logic [1:0] rsp_tag;
    logic [1:0] rsp_err;
    logic       busy;
    logic [2:0] count;

    div_job_sequencer #(
        .DEPTH  (4),
        .TAG_W  (2),
        .TIMEOUT(31)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_divisor  (req_divisor),
        .req_dividend (req_dividend),
        .req_tag      (req_tag),
        .div_divisor  (div_divisor),
        .div_dividend (div_dividend),
        .div_start    (div_start),
        .div_valid    (div_valid),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_quotient (rsp_quotient),
        .rsp_remainder(rsp_remainder),
        .rsp_tag      (rsp_tag),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .count        (count)
    );

    typedef struct {
        logic [7:0] q;
        logic [6:0] r;
        logic [1:0] tag;
        logic [1:0] err;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int starts = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int resp_count = 0;
    int last_lat = 0;

    // Divider model controls
    bit stall = 0;
    bit stale_hold = 0;
    bit kick = 0;
    int div_lat = 3;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [6:0] dvs, input logic [7:0] dvd, input logic [1:0] tag,
                        input logic [7:0] eq, input logic [6:0] er, input logic [1:0] ee,
                        input bit exp_rsp, output int acc);
        int n;
        exp_t e;
        n = 0;
        req_divisor  = dvs;
        req_dividend = dvd;
        req_tag      = tag;
        req_valid    = 1'b1;
        while (!req_ready && n < 200) begin
            step(1);
            n++;
        end
        check("send_ready", req_ready, 1);
        acc = cyc;
        if (exp_rsp) begin
            e.q = eq; e.r = er; e.tag = tag; e.err = ee;
            exp_q.push_back(e);
        end
        step(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (resp_count < target && n < budget) begin
            step(1);
            n++;
        end
        check(name, resp_count, target);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Behavioural divider: valid is a level held until the next start is sampled.
    initial begin
        logic       st, rs;
        logic [6:0] sd;
        logic [7:0] sv;
        logic [7:0] nq;
        logic [6:0] nr;
        bit         pend, drop_next;
        int         cnt;
        div_valid = 1'b0; div_quotient = '0; div_remainder = '0;
        pend = 0; drop_next = 0; cnt = 0; nq = '0; nr = '0;
        forever begin
            @(negedge clk);
            st = div_start; rs = reset; sd = div_divisor; sv = div_dividend;
            @(posedge clk);
            #2;
            if (rs) begin
                div_valid = 1'b0; pend = 0; drop_next = 0;
            end else begin
                if (drop_next) begin
                    div_valid = 1'b0;
                    drop_next = 0;
                end
                if (st) begin
                    if (stale_hold) drop_next = 1;
                    else div_valid = 1'b0;
                    pend = 1;
                    cnt  = div_lat;
                    nq   = 8'(int'(sv) / int'(sd));
                    nr   = 7'(int'(sv) % int'(sd));
                end else if (pend && !stall) begin
                    if (cnt == 0) begin
                        div_valid = 1'b1; div_quotient = nq; div_remainder = nr; pend = 0;
                    end else begin
                        cnt--;
                    end
                end
                if (kick) begin
                    div_valid = 1'b1;
                    kick = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        logic        prev_v;
        bit          hold_pending;
        logic [18:0] held;
        exp_t        e;
        prev_v = 1'b0; hold_pending = 0; held = '0;
        forever begin
            @(negedge clk);
            if (div_start) begin
                start_cyc = cyc;
                starts++;
            end
            if (rsp_valid && !prev_v) rise_cyc = cyc;
            if (hold_pending && !reset) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_data", {rsp_quotient, rsp_remainder, rsp_tag, rsp_err}, held);
            end
            hold_pending = rsp_valid && !rsp_ready;
            held = {rsp_quotient, rsp_remainder, rsp_tag, rsp_err};
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_quotient", rsp_quotient, e.q);
                    check("rsp_remainder", rsp_remainder, e.r);
                    check("rsp_tag", rsp_tag, e.tag);
                    check("rsp_err", rsp_err, e.err);
                end
                last_lat = rise_cyc - start_cyc - 1;
                resp_count++;
            end
            prev_v = rsp_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, s0, base;
        reset = 1'b1; req_valid = 1'b0; req_divisor = '0; req_dividend = '0; req_tag = '0;
        rsp_ready = 1'b1;
        step(3);
        reset = 1'b0;

        check("rst_req_ready", req_ready, 1);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_div_start", div_start, 0);
        check("rst_div_operands", {div_divisor, div_dividend}, 0);

        // 1: single op 100/7
        div_lat = 3; s0 = starts; base = resp_count;
        send(7'd7, 8'd100, 2'd1, 8'd14, 7'd2, 2'b00, 1, acc);
        wait_resp("t1_resp", base + 1, 50);
        check("t1_start_cycle", start_cyc, acc + 2);
        check("t1_start_width", starts - s0, 1);
        check("t1_latency", last_lat, 5);
        check("t1_busy_after", busy, 0);

        // 2: divide by zero
        s0 = starts; base = resp_count;
        send(7'd0, 8'd200, 2'd2, 8'hFF, 7'd72, 2'b01, 1, acc);
        wait_resp("t2_resp", base + 1, 50);
        check("t2_rsp_cycle", rise_cyc, acc + 2);
        step(3);
        check("t2_no_start", starts - s0, 0);

        // 3: full FIFO and backpressure
        div_lat = 2; stall = 1; rsp_ready = 1'b0; base = resp_count;
        fork
            begin
                send(7'd7,  8'd100, 2'd0, 8'd14,  7'd2,  2'b00, 1, acc);
                send(7'd16, 8'd255, 2'd1, 8'd15,  7'd15, 2'b00, 1, acc);
                send(7'd3,  8'd9,   2'd2, 8'd3,   7'd0,  2'b00, 1, acc);
                send(7'd20, 8'd17,  2'd3, 8'd0,   7'd17, 2'b00, 1, acc);
                send(7'd1,  8'd128, 2'd0, 8'd128, 7'd0,  2'b00, 1, acc);
                send(7'd9,  8'd200, 2'd1, 8'd22,  7'd2,  2'b00, 1, acc);
                check("t3_sixth_after_hs", (resp_count > base) ? 1 : 0, 1);
            end
            begin
                step(8);
                check("t3_count_full", count, 4);
                check("t3_req_ready_low", req_ready, 0);
                check("t3_no_rsp_yet", rsp_valid, 0);
                stall = 0;
                step(10);
                check("t3_rsp_held", rsp_valid, 1);
                rsp_ready = 1'b1;
            end
        join
        wait_resp("t3_resp", base + 6, 400);

        // 4: timeout, then the queued job runs normally
        div_lat = 3; stall = 1; base = resp_count;
        send(7'd4, 8'd60, 2'd2, 8'd0,  7'd0, 2'b10, 1, acc);
        send(7'd4, 8'd60, 2'd3, 8'd15, 7'd0, 2'b00, 1, acc);
        wait_resp("t4_timeout_resp", base + 1, 100);
        check("t4_timeout_latency", last_lat, 32);
        stall = 0;
        wait_resp("t4_next_resp", base + 2, 100);

        // 5: stale valid held into WAIT, real rise 12 cycles after WAIT entry
        stale_hold = 1; div_lat = 10; base = resp_count;
        send(7'd6, 8'd77, 2'd0, 8'd12, 7'd5, 2'b00, 1, acc);
        wait_resp("t5_resp", base + 1, 100);
        check("t5_latency", last_lat, 12);
        stale_hold = 0;

        // 6: reset mid-WAIT with two jobs queued
        div_lat = 3; stall = 1; base = resp_count; s0 = starts;
        send(7'd3, 8'd30, 2'd0, 8'd10, 7'd0, 2'b00, 0, acc);
        send(7'd3, 8'd31, 2'd1, 8'd10, 7'd1, 2'b00, 0, acc);
        send(7'd3, 8'd32, 2'd2, 8'd10, 7'd2, 2'b00, 0, acc);
        step(2);
        check("t6_count_queued", count, 2);
        check("t6_one_started", starts - s0, 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t6_count", count, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_div_start", div_start, 0);
        check("t6_req_ready", req_ready, 1);
        check("t6_busy", busy, 0);
        stall = 0;
        step(2);
        kick = 1;
        step(40);
        check("t6_no_late_rsp", resp_count, base);
        check("t6_no_restart", starts - s0, 1);
        check("t6_idle_after", busy, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
